instr_encoder: RTL and testbench

RV32I instruction encoder: the inverse of the decode/control path. Accepts decoded fields (instruction class, 4-bit ALU operation code, register indices, immediate, memory width) over a valid/ready handshake. Packs them into a 32-bit RV32I instruction word and delivers the words in order through a 2-entry output FIFO with a valid/ready handshake. Used by the self-test program generator and the instruction-memory loader; illegal field combinations are flagged and counted.

---
 rtl/instr_encoder.sv | 204 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit instruction words.
//
// Requests arrive over a valid/ready handshake, are encoded combinationally,
// and are queued in a 2-entry FIFO that presents words in order over a second
// valid/ready handshake. Illegal field combinations are replaced with a NOP
// (0x00000013), tagged with out_illegal, and counted in a saturating counter.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid/ready   request handshake; in_ready depends on FIFO occupancy only
//   in_kind          instruction class (0..8 legal)
//   in_alu_ctrl      ALU / branch operation code
//   in_mem_f3        load/store width funct3
//   in_rd/rs1/rs2    register indices
//   in_imm           immediate (byte offset for branches/jumps)
//   out_valid/ready  output handshake at FIFO head
//   out_instr        encoded word at FIFO head (0 when empty)
//   out_illegal      head entry came from an illegal request
//   illegal_cnt      saturating count of accepted illegal requests
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_kind,
    input  logic [3:0]       in_alu_ctrl,
    input  logic [2:0]       in_mem_f3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [3:0] {
        KIND_R      = 4'd0,
        KIND_I_ALU  = 4'd1,
        KIND_LOAD   = 4'd2,
        KIND_STORE  = 4'd3,
        KIND_BRANCH = 4'd4,
        KIND_LUI    = 4'd5,
        KIND_AUIPC  = 4'd6,
        KIND_JAL    = 4'd7,
        KIND_JALR   = 4'd8
    } kind_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_BEQ  = 4'hA,
        ALU_BNE  = 4'hB,
        ALU_BLT  = 4'hC,
        ALU_BGE  = 4'hD,
        ALU_BLTU = 4'hE,
        ALU_BGEU = 4'hF
    } alu_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Field encoding
    // ------------------------------------------------------------------
    logic [2:0]  alu_f3;
    logic [2:0]  br_f3;
    logic [6:0]  funct7;
    logic        is_shift;
    logic        alu_op_ok;
    logic [31:0] enc_word;
    logic        illegal;
    logic [31:0] push_word;

    always_comb begin
        alu_f3    = '0;
        br_f3     = '0;
        is_shift  = 1'b0;
        alu_op_ok = (in_alu_ctrl < 4'hA);
        funct7    = ((in_alu_ctrl == ALU_SUB) || (in_alu_ctrl == ALU_SRA))
                    ? 7'b0100000 : 7'b0000000;
        case (in_alu_ctrl)
            ALU_ADD, ALU_SUB: alu_f3 = 3'b000;
            ALU_SLL:  begin alu_f3 = 3'b001; is_shift = 1'b1; end
            ALU_SLT:  alu_f3 = 3'b010;
            ALU_SLTU: alu_f3 = 3'b011;
            ALU_XOR:  alu_f3 = 3'b100;
            ALU_SRL, ALU_SRA: begin alu_f3 = 3'b101; is_shift = 1'b1; end
            ALU_OR:   alu_f3 = 3'b110;
            ALU_AND:  alu_f3 = 3'b111;
            ALU_BEQ:  br_f3  = 3'b000;
            ALU_BNE:  br_f3  = 3'b001;
            ALU_BLT:  br_f3  = 3'b100;
            ALU_BGE:  br_f3  = 3'b101;
            ALU_BLTU: br_f3  = 3'b110;
            ALU_BGEU: br_f3  = 3'b111;
            default:  ;
        endcase
    end

    always_comb begin
        enc_word = '0;
        illegal  = 1'b0;
        case (in_kind)
            KIND_R: begin
                enc_word = {funct7, in_rs2, in_rs1, alu_f3, in_rd, 7'b0110011};
                illegal  = !alu_op_ok;
            end
            KIND_I_ALU: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (is_shift)
                    enc_word = {funct7, in_imm[4:0], in_rs1, alu_f3, in_rd, 7'b0010011};
                else
                    enc_word = {in_imm[11:0], in_rs1, alu_f3, in_rd, 7'b0010011};
                illegal = !alu_op_ok || (in_alu_ctrl == ALU_SUB);
            end
            KIND_LOAD: begin
                enc_word = {in_imm[11:0], in_rs1, in_mem_f3, in_rd, 7'b0000011};
                illegal  = (in_mem_f3 == 3'b011) || (in_mem_f3 == 3'b110) ||
                           (in_mem_f3 == 3'b111);
            end
            KIND_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_mem_f3, in_imm[4:0],
                            7'b0100011};
                illegal  = (in_mem_f3 >= 3'b011);
            end
            KIND_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, br_f3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                illegal  = alu_op_ok || in_imm[0];
            end
            KIND_LUI:   enc_word = {in_imm[31:12], in_rd, 7'b0110111};
            KIND_AUIPC: enc_word = {in_imm[31:12], in_rd, 7'b0010111};
            KIND_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, 7'b1101111};
                illegal  = in_imm[0];
            end
            KIND_JALR:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            default:    illegal = 1'b1;
        endcase
        push_word = illegal ? NOP : enc_word;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [32:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign in_ready    = (count < 2'(DEPTH));
    assign out_valid   = (count != 2'd0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    // Head is masked when empty so a drained FIFO reads back as zero.
    assign out_instr   = out_valid ? mem[rd_ptr][31:0] : '0;
    assign out_illegal = out_valid ? mem[rd_ptr][32]   : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {illegal, push_word};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (push && illegal && (illegal_cnt != '1))
            illegal_cnt <= illegal_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: scoreboard of expected words pushed on
// acceptance, compared by a monitor whenever the DUT pops its FIFO head.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = '0;
    logic [3:0]  in_alu_ctrl = '0;
    logic [2:0]  in_mem_f3 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_illegal;
    logic [7:0]  illegal_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    instr_encoder #(.DEPTH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_alu_ctrl(in_alu_ctrl),
        .in_mem_f3  (in_mem_f3),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every pop is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected got=%08h exp=<none>", out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_instr !== e.instr || out_illegal !== e.ill) begin
                    failures++;
                    $display("FAIL pop_word got=%08h/%0b exp=%08h/%0b",
                             out_instr, out_illegal, e.instr, e.ill);
                end
            end
        end
    end

    // Drive one request; push its expectation when the DUT accepts it.
    task automatic send(input logic [3:0] k, input logic [3:0] a, input logic [2:0] f,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] exp_instr,
                        input logic exp_ill);
        int unsigned t = 0;
        @(negedge clk);
        in_kind = k; in_alu_ctrl = a; in_mem_f3 = f;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=in_ready=0 exp=in_ready=1");
        end else begin
            exp_q.push_back('{instr: exp_instr, ill: exp_ill});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%08h exp=0", out_instr); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_out_illegal got=%0b exp=0", out_illegal); end
        checks++; if (illegal_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", illegal_cnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_encode();
        out_ready = 1'b1;
        send(4'd0, 4'h0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0); // ADD
        send(4'd0, 4'h1, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h402081B3, 1'b0); // SUB
        send(4'd0, 4'h7, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h4020D1B3, 1'b0); // SRA
        send(4'd1, 4'h0, 3'd0, 5'd1, 5'd0, 5'd9, 32'd5,        32'h00500093, 1'b0); // ADDI
        send(4'd1, 4'h7, 3'd0, 5'd5, 5'd6, 5'd0, 32'd3,        32'h40335293, 1'b0); // SRAI
        send(4'd1, 4'h9, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF13093, 1'b0); // SLTIU -1
        send(4'd4, 4'hA, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h00208463, 1'b0); // BEQ +8
        send(4'd4, 4'hB, 3'd0, 5'd0, 5'd3, 5'd0, 32'hFFFFFFF8, 32'hFE019CE3, 1'b0); // BNE -8
        send(4'd5, 4'h3, 3'd0, 5'd1, 5'd7, 5'd9, 32'h12345000, 32'h123450B7, 1'b0); // LUI
        send(4'd3, 4'h0, 3'd2, 5'd0, 5'd2, 5'd5, 32'd12,       32'h00512623, 1'b0); // SW
        send(4'd2, 4'h0, 3'd2, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'hFFC12283, 1'b0); // LW -4
        send(4'd2, 4'h0, 3'd4, 5'd1, 5'd2, 5'd0, 32'd0,        32'h00014083, 1'b0); // LBU
        send(4'd7, 4'h0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0); // JAL
        send(4'd8, 4'h0, 3'd0, 5'd0, 5'd1, 5'd0, 32'd0,        32'h00008067, 1'b0); // JALR
        send(4'd6, 4'h0, 3'd0, 5'd2, 5'd0, 5'd0, 32'h00001000, 32'h00001117, 1'b0); // AUIPC
        wait_drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL encode_drain got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(4'd4, 4'h0, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00000013, 1'b1); // BRANCH with ADD
        send(4'd1, 4'h1, 3'd0, 5'd1, 5'd1, 5'd0, 32'd5, 32'h00000013, 1'b1); // I-ALU SUB
        wait_drain();
        checks++; if (illegal_cnt !== 8'd2) begin failures++; $display("FAIL illegal_cnt2 got=%0d exp=2", illegal_cnt); end
        send(4'd9, 4'h0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h00000013, 1'b1); // kind 9
        send(4'd0, 4'hA, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h00000013, 1'b1); // R with BEQ
        send(4'd2, 4'h0, 3'd3, 5'd1, 5'd1, 5'd0, 32'd0, 32'h00000013, 1'b1); // LOAD f3=011
        send(4'd3, 4'h0, 3'd3, 5'd0, 5'd1, 5'd1, 32'd0, 32'h00000013, 1'b1); // STORE f3=011
        send(4'd7, 4'h0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd9, 32'h00000013, 1'b1); // JAL odd
        send(4'd4, 4'hA, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00000013, 1'b1); // BEQ odd
        wait_drain();
        checks++; if (illegal_cnt !== 8'd8) begin failures++; $display("FAIL illegal_cnt8 got=%0d exp=8", illegal_cnt); end
        for (int i = 0; i < 300; i++)
            send(4'd15, 4'h0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h00000013, 1'b1);
        wait_drain();
        checks++; if (illegal_cnt !== 8'd255) begin failures++; $display("FAIL illegal_sat got=%0d exp=255", illegal_cnt); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        logic [31:0] first_word;
        out_ready = 1'b0;
        first_word = 32'h00208033 | (32'd1 << 7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_kind = 4'd0; in_alu_ctrl = 4'h0; in_rs1 = 5'd1; in_rs2 = 5'd2;
            in_rd = 5'(i + 1); in_valid = 1'b1;
            if (in_ready) begin
                exp_q.push_back('{instr: 32'h00208033 | ((i + 1) << 7), ill: 1'b0});
                accepted++;
            end
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (accepted != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", accepted); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
        checks++; if (out_instr !== first_word) begin failures++; $display("FAIL bp_hold1 got=%08h exp=%08h", out_instr, first_word); end
        @(negedge clk);
        checks++; if (out_instr !== first_word || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold2 got=%08h/%0b exp=%08h/1", out_instr, out_valid, first_word); end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain got=%0d exp=0", exp_q.size()); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_after got=%0b/%0b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(4'd0, 4'h0, 3'd0, 5'd1, 5'd1, 5'd2, 32'd0, 32'h002080B3, 1'b0);
        out_ready = 1'b1;
        send(4'd0, 4'h0, 3'd0, 5'd2, 5'd1, 5'd2, 32'd0, 32'h00208133, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_count1 got=%0b/%0b exp=1/1", out_valid, in_ready); end
        checks++; if (out_instr !== 32'h00208133) begin failures++; $display("FAIL b2b_head got=%08h exp=00208133", out_instr); end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send(4'd0, 4'h0, 3'd0, 5'd1, 5'd1, 5'd2, 32'd0, 32'h002080B3, 1'b0);
        send(4'd9, 4'h0, 3'd0, 5'd1, 5'd1, 5'd2, 32'd0, 32'h00000013, 1'b1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mr_full got=%0b exp=0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mr_flush got=%0b/%0b exp=0/1", out_valid, in_ready); end
        checks++; if (illegal_cnt !== 8'd0 || out_instr !== 32'h0) begin failures++; $display("FAIL mr_clear got=%0d/%08h exp=0/0", illegal_cnt, out_instr); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(4'd0, 4'h0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_illegal !== 1'b0) begin
            failures++; $display("FAIL mr_latency got=%0b/%08h exp=1/002081B3", out_valid, out_instr);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mr_drain got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
